// File: rtl/sbox_layer_ctrl.sv
// sbox_layer_ctrl: time-multiplexed Ascon substitution layer over the 320-bit state
//   clock_i/reset_i : clock, synchronous active-high reset
//   start_i/state_i : start a pass over state_i {x0..x4}, x0 in [319:256]
//   state_o         : substituted state, valid from done_o until the next accepted start
//   busy_o/done_o   : pass running / one-cycle completion pulse
module sbox_layer_ctrl_sbox (
  input  logic [4:0] a_i,
  output logic [4:0] y_o
);
  logic b0, b1, b2, b3, b4, c0, c1, c2, c3, c4;
  assign b0 = a_i[4] ^ a_i[0];
  assign b1 = a_i[3];
  assign b2 = a_i[2] ^ a_i[3];
  assign b3 = a_i[1];
  assign b4 = a_i[0] ^ a_i[1];
  assign c0 = b0 ^ (~b1 & b2);
  assign c1 = b1 ^ (~b2 & b3);
  assign c2 = b2 ^ (~b3 & b4);
  assign c3 = b3 ^ (~b4 & b0);
  assign c4 = b4 ^ (~b0 & b1);
  assign y_o = {c0 ^ c4, c1 ^ c0, ~c2, c3 ^ c2, c4};
endmodule

module sbox_layer_ctrl #(
  parameter int NB_SBOX = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam int N = 64 / NB_SBOX;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (64 % NB_SBOX != 0) begin : g_bad_nb
    $error("NB_SBOX must divide 64");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  st_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [319:0] state_q, state_d;
  logic [63:0] x [5];
  logic [63:0] y [5];
  logic [5:0] col [NB_SBOX];
  logic [4:0] s_in [NB_SBOX];
  logic [4:0] s_out [NB_SBOX];
  logic last;
  for (genvar g = 0; g < NB_SBOX; g++) begin : g_sbox
    assign col[g] = 6'(32'(cnt_q) * NB_SBOX + g);
    assign s_in[g] = {x[0][col[g]], x[1][col[g]], x[2][col[g]], x[3][col[g]], x[4][col[g]]};
    sbox_layer_ctrl_sbox u_sbox (.a_i(s_in[g]), .y_o(s_out[g]));
  end
  always_comb begin
    for (int b = 0; b < 5; b++) x[b] = state_q[319-64*b -: 64];
    y = x;
    for (int i = 0; i < NB_SBOX; i++)
      for (int b = 0; b < 5; b++) y[b][col[i]] = s_out[i][4-b];
  end
  assign last = cnt_q == CW'(N - 1);
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    state_d = state_q;
    unique case (st_q)
      RUN: begin
        state_d = {y[0], y[1], y[2], y[3], y[4]};
        cnt_d = last ? '0 : cnt_q + 1'b1;
        st_d = last ? DONE : RUN;
      end
      default: begin
        if (start_i) begin
          state_d = state_i;
          cnt_d = '0;
          st_d = RUN;
        end else if (st_q == DONE) begin
          st_d = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st_q <= IDLE;
      cnt_q <= '0;
      state_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
  assign state_o = state_q;
  assign busy_o = st_q == RUN;
  assign done_o = st_q == DONE;
endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// tb_sbox_layer_ctrl: checks NB_SBOX=1,8,64 instances against a table-driven substitution model
module tb_sbox_layer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [319:0] sin = '0;
  logic [319:0] so [3];
  logic busy [3];
  logic done [3];
  int checks = 0;
  int errors = 0;
  int ns [3] = '{64, 8, 1};
  logic [4:0] tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                           5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                           5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                           5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 clk = ~clk;

  sbox_layer_ctrl #(.NB_SBOX(1)) d1 (.clock_i(clk), .reset_i(rst), .start_i(start), .state_i(sin),
    .state_o(so[0]), .busy_o(busy[0]), .done_o(done[0]));
  sbox_layer_ctrl #(.NB_SBOX(8)) d8 (.clock_i(clk), .reset_i(rst), .start_i(start), .state_i(sin),
    .state_o(so[1]), .busy_o(busy[1]), .done_o(done[1]));
  sbox_layer_ctrl #(.NB_SBOX(64)) d64 (.clock_i(clk), .reset_i(rst), .start_i(start), .state_i(sin),
    .state_o(so[2]), .busy_o(busy[2]), .done_o(done[2]));

  function automatic logic [319:0] layer(input logic [319:0] s);
    logic [319:0] r;
    logic [4:0] v;
    r = s;
    for (int j = 0; j < 64; j++) begin
      v = tab[{s[256+j], s[192+j], s[128+j], s[64+j], s[j]}];
      {r[256+j], r[192+j], r[128+j], r[64+j], r[j]} = v;
    end
    return r;
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input int inst, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s nb=%0d observed=%h expected=%h", tag, 64 / ns[inst], obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input logic [319:0] s, input int span);
    logic [319:0] exp;
    exp = layer(s);
    sin = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    sin = rnd320();
    for (int c = 1; c <= span; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("busy", i, 320'(busy[i]), 320'(c >= 1 && c <= ns[i]));
        chk("done", i, 320'(done[i]), 320'(c == ns[i] + 1));
        if (c >= ns[i] + 1) chk("state", i, so[i], exp);
      end
      tick();
    end
  endtask

  initial begin
    logic [319:0] s, exp;
    logic [4:0] v;
    tick();
    tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 320'(busy[i]), '0);
      chk("rst_done", i, 320'(done[i]), '0);
      chk("rst_state", i, so[i], '0);
    end
    tick();
    rst = 1'b0;
    tick();
    run_pass('0, 66);
    chk("zero_const", 1, so[1], {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});
    run_pass('1, 66);
    chk("ones_const", 1, so[1], {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, {3{64'hFFFF_FFFF_FFFF_FFFF}}});
    for (int j = 0; j < 64; j++) begin
      v = 5'(j % 32);
      {s[256+j], s[192+j], s[128+j], s[64+j], s[j]} = v;
    end
    run_pass(s, 66);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 64; j++)
        chk($sformatf("col%0d", j), i, 320'({so[i][256+j], so[i][192+j], so[i][128+j], so[i][64+j], so[i][j]}),
            320'(tab[j % 32]));
    for (int r = 0; r < 3; r++) run_pass(rnd320(), 66);
    s = rnd320();
    exp = layer(s);
    sin = s;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("held_busy", i, 320'(busy[i]), 320'(c % (ns[i] + 1) != 0));
        chk("held_done", i, 320'(done[i]), 320'(c % (ns[i] + 1) == 0));
        if (c % (ns[i] + 1) == 0) chk("held_state", i, so[i], exp);
      end
      tick();
    end
    start = 1'b0;
    repeat (70) tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("held_idle", i, 320'(busy[i] | done[i]), '0);
    tick();
    sin = rnd320();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("abort_busy", i, 320'(busy[i]), '0);
        chk("abort_done", i, 320'(done[i]), '0);
        chk("abort_state", i, so[i], '0);
      end
      tick();
    end
    sin = rnd320();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rststart_busy", i, 320'(busy[i]), '0);
      chk("rststart_done", i, 320'(done[i]), '0);
      chk("rststart_state", i, so[i], '0);
    end
    tick();
    run_pass(rnd320(), 66);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
